// File: rtl/axi_rd_arbiter.sv
// Round-robin arbiter sharing one AXI read port between N requesters, one burst at a time.
// R beats are routed combinationally to the granted requester; protocol violations set a sticky err.
module axi_rd_arbiter #(
  parameter int unsigned N = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N-1:0]      req_arvalid,
  input  logic [64*N-1:0]   req_araddr,
  input  logic [8*N-1:0]    req_arlen,
  output logic [N-1:0]      req_arready,
  output logic [511:0]      req_rdata,
  output logic [1:0]        req_rresp,
  output logic              req_rlast,
  output logic [N-1:0]      req_rvalid,
  input  logic [N-1:0]      req_rready,
  output logic [15:0]       arid_m,
  output logic [63:0]       araddr_m,
  output logic [7:0]        arlen_m,
  output logic [2:0]        arsize_m,
  output logic              arvalid_m,
  input  logic              arready_m,
  input  logic [15:0]       rid_m,
  input  logic [511:0]      rdata_m,
  input  logic [1:0]        rresp_m,
  input  logic              rlast_m,
  input  logic              rvalid_m,
  output logic              rready_m,
  output logic              err,
  output logic              busy
);

  localparam int unsigned AW = 64;
  localparam int unsigned LW = 8;
  localparam int unsigned IW = 16;
  localparam int unsigned GW = 4;
  localparam int unsigned CW = 9;

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  state_t          state_q, state_d;
  logic [GW-1:0]   grant_q, last_grant_q, gnt_idx;
  logic            gnt_found;
  logic [AW-1:0]   addr_q, gnt_addr;
  logic [LW-1:0]   len_q, gnt_len;
  logic [CW-1:0]   cnt_q;
  logic            err_q;
  logic            sel_rready;
  logic            req_hs, beat_hs, beat_err;
  logic            unused_rid_hi;

  assign unused_rid_hi = |rid_m[IW-1:GW];

  // Round-robin search: first valid requester starting at last_grant+1 modulo N
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    for (int unsigned i = 1; i <= N; i++) begin
      for (int unsigned k = 0; k < N; k++) begin
        if (!gnt_found && req_arvalid[k] && ((32'(last_grant_q) + i) % N == k)) begin
          gnt_found = 1'b1;
          gnt_idx   = GW'(k);
        end
      end
    end
  end

  always_comb begin
    gnt_addr   = '0;
    gnt_len    = '0;
    sel_rready = 1'b0;
    for (int unsigned k = 0; k < N; k++) begin
      if (GW'(k) == gnt_idx) begin
        gnt_addr = req_araddr[AW*k +: AW];
        gnt_len  = req_arlen[LW*k +: LW];
      end
      if (GW'(k) == grant_q) sel_rready = req_rready[k];
    end
  end

  assign req_hs  = (state_q == IDLE) && gnt_found;
  assign beat_hs = (state_q == DATA) && rvalid_m && sel_rready;

  // Length check is exact over 256 beats because cnt is one bit wider than len
  assign beat_err = (rid_m[GW-1:0] != grant_q) || (rresp_m != 2'd0) ||
                    ( rlast_m && (cnt_q != CW'(len_q))) ||
                    (!rlast_m && (cnt_q == CW'(len_q)));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    req_arready = '0;
    req_rvalid  = '0;
    arvalid_m   = 1'b0;
    rready_m    = 1'b0;
    case (state_q)
      IDLE: begin
        for (int unsigned k = 0; k < N; k++)
          req_arready[k] = gnt_found && (GW'(k) == gnt_idx);
        if (gnt_found) state_d = ADDR;
      end
      ADDR: begin
        arvalid_m = 1'b1;
        if (arready_m) state_d = DATA;
      end
      DATA: begin
        rready_m = sel_rready;
        for (int unsigned k = 0; k < N; k++)
          req_rvalid[k] = rvalid_m && (GW'(k) == grant_q);
        if (beat_hs && rlast_m) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      grant_q      <= '0;
      last_grant_q <= GW'(N - 1);
      addr_q       <= '0;
      len_q        <= '0;
      cnt_q        <= '0;
      err_q        <= 1'b0;
    end else begin
      if (req_hs) begin
        grant_q <= gnt_idx;
        addr_q  <= gnt_addr;
        len_q   <= gnt_len;
        cnt_q   <= '0;
      end
      if (beat_hs) begin
        cnt_q <= cnt_q + CW'(1);
        if (beat_err) err_q <= 1'b1;
        if (rlast_m)  last_grant_q <= grant_q;
      end
    end
  end

  assign arid_m    = IW'(grant_q);
  assign araddr_m  = addr_q;
  assign arlen_m   = len_q;
  assign arsize_m  = 3'd6;
  assign req_rdata = rdata_m;
  assign req_rresp = rresp_m;
  assign req_rlast = rlast_m;
  assign err       = err_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Self-checking bench for axi_rd_arbiter: vector table of single bursts, hand-written
// contention/reset sequences, and randomized traffic against a round-robin reference model.
module tb_axi_rd_arbiter;

  localparam int N = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [N-1:0]      req_arvalid = '0;
  logic [64*N-1:0]   req_araddr = '0;
  logic [8*N-1:0]    req_arlen = '0;
  logic [N-1:0]      req_arready;
  logic [511:0]      req_rdata;
  logic [1:0]        req_rresp;
  logic              req_rlast;
  logic [N-1:0]      req_rvalid;
  logic [N-1:0]      req_rready = '0;
  logic [15:0]       arid_m;
  logic [63:0]       araddr_m;
  logic [7:0]        arlen_m;
  logic [2:0]        arsize_m;
  logic              arvalid_m;
  logic              arready_m = 1'b0;
  logic [15:0]       rid_m = '0;
  logic [511:0]      rdata_m = '0;
  logic [1:0]        rresp_m = '0;
  logic              rlast_m = 1'b0;
  logic              rvalid_m = 1'b0;
  logic              rready_m;
  logic              err;
  logic              busy;

  int checks = 0;
  int errors = 0;

  axi_rd_arbiter #(.N(N)) dut (
    .clk(clk), .rst(rst),
    .req_arvalid(req_arvalid), .req_araddr(req_araddr), .req_arlen(req_arlen),
    .req_arready(req_arready), .req_rdata(req_rdata), .req_rresp(req_rresp),
    .req_rlast(req_rlast), .req_rvalid(req_rvalid), .req_rready(req_rready),
    .arid_m(arid_m), .araddr_m(araddr_m), .arlen_m(arlen_m), .arsize_m(arsize_m),
    .arvalid_m(arvalid_m), .arready_m(arready_m), .rid_m(rid_m), .rdata_m(rdata_m),
    .rresp_m(rresp_m), .rlast_m(rlast_m), .rvalid_m(rvalid_m), .rready_m(rready_m),
    .err(err), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          req;
    logic [63:0] addr;
    logic [7:0]  len;
    logic [1:0]  resp;
    bit          bad_id;
    int          early;    // beat index carrying an early rlast, -1 for none
    bit          bp;       // toggle req_rready every other cycle
    bit          exp_err;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [N-1:0] one_hot(input int g);
    return N'(1) << g;
  endfunction

  // Reference arbitration: first valid requester after last, wrapping modulo N
  function automatic int rr_pick(input int last, input logic [N-1:0] mask);
    for (int i = 1; i <= N; i++) begin
      if (mask[(last + i) % N]) return (last + i) % N;
    end
    return -1;
  endfunction

  task automatic clear_r();
    rvalid_m = 1'b0; rlast_m = 1'b0; rresp_m = '0; rid_m = '0;
    req_rready = '0; arready_m = 1'b0;
  endtask

  task automatic do_reset();
    req_arvalid = '0;
    clear_r();
    rst = 1'b0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_arvalid", arvalid_m, 0);
    chk("rst_rready", rready_m, 0);
    chk("rst_rvalid", req_rvalid, 0);
    chk("rst_err", err, 0);
    step(); step();
    rst = 1'b1;
    #1;
  endtask

  task automatic run_vec(input vec_t v);
    logic [N-1:0] m;
    logic [63:0]  d;
    int b, cyc, last_at;
    bit done;
    do_reset();
    m = one_hot(v.req);
    req_arvalid = m;
    req_araddr[64*v.req +: 64] = v.addr;
    req_arlen[8*v.req +: 8] = v.len;
    #1;
    chk("v_arready", req_arready, m);
    step();
    req_arvalid = '0;
    #1;
    chk("v_arvalid", arvalid_m, 1);
    chk("v_arid", arid_m, 64'(v.req));
    chk("v_araddr", araddr_m, v.addr);
    chk("v_arlen", arlen_m, 64'(v.len));
    chk("v_arsize", arsize_m, 6);
    chk("v_busy", busy, 1);
    arready_m = 1'b1;
    step();
    arready_m = 1'b0;
    last_at = (v.early >= 0) ? v.early : int'(v.len);
    b = 0; cyc = 0; done = 1'b0;
    while (!done && cyc < 4 * (int'(v.len) + 1) + 20) begin
      d = v.addr + 64'(b);
      rvalid_m = 1'b1;
      rid_m = v.bad_id ? 16'(v.req ^ 1) : 16'(v.req);
      rresp_m = v.resp;
      rlast_m = (b == last_at);
      rdata_m = {8{d}};
      req_rready = (v.bp && (cyc % 2 == 0)) ? '0 : m;
      #1;
      chk("v_rvalid", req_rvalid, m);
      chk("v_rready_m", rready_m, req_rready[v.req]);
      chk("v_rdata_lo", req_rdata[63:0], d);
      chk("v_rdata_hi", req_rdata[511:448], d);
      chk("v_rlast", req_rlast, (b == last_at));
      if (req_rready[v.req]) begin
        b++;
        if (rlast_m) done = 1'b1;
      end
      step();
      cyc++;
    end
    chk("v_burst_done", done, 1);
    clear_r();
    #1;
    chk("v_beats", 64'(b), 64'(last_at + 1));
    chk("v_idle", busy, 0);
    chk("v_err", err, v.exp_err);
  endtask

  initial begin
    int exp_order[5];
    int last, g, b, len, waits;
    bit done;
    logic [N-1:0] mask;
    logic [63:0] addrs[N];
    logic [7:0]  lens[N];
    logic [63:0] d;

    vecs[0] = '{2, 64'h1000,      8'd3,   2'd0, 1'b0, -1, 1'b0, 1'b0};
    vecs[1] = '{1, 64'h2040,      8'd7,   2'd0, 1'b0, -1, 1'b1, 1'b0};
    vecs[2] = '{0, 64'hABCD_0000, 8'd255, 2'd0, 1'b0, -1, 1'b0, 1'b0};
    vecs[3] = '{3, 64'h3000,      8'd3,   2'd0, 1'b0,  1, 1'b0, 1'b1};
    vecs[4] = '{1, 64'h4000,      8'd2,   2'd2, 1'b0, -1, 1'b0, 1'b1};
    vecs[5] = '{2, 64'h5000,      8'd1,   2'd0, 1'b1, -1, 1'b0, 1'b1};
    exp_order = '{0, 1, 2, 3, 0};

    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // Contention: all valid, len 0, grants rotate and each burst takes 3 cycles
    do_reset();
    for (int k = 0; k < N; k++) begin
      req_araddr[64*k +: 64] = 64'(k) << 8;
      req_arlen[8*k +: 8] = 8'd0;
    end
    req_arvalid = '1;
    for (int n = 0; n < 5; n++) begin
      g = exp_order[n];
      #1;
      chk("c_arready", req_arready, one_hot(g));
      chk("c_idle", busy, 0);
      step();
      chk("c_arvalid", arvalid_m, 1);
      chk("c_arid", arid_m, 64'(g));
      arready_m = 1'b1;
      step();
      arready_m = 1'b0;
      rvalid_m = 1'b1; rlast_m = 1'b1; rid_m = 16'(g); req_rready = '1;
      #1;
      chk("c_rvalid", req_rvalid, one_hot(g));
      chk("c_rready", rready_m, 1);
      step();
      clear_r();
    end
    req_arvalid = '0;
    chk("c_err", err, 0);

    // Reset mid-burst: beat 3 of len 7 on requester 1
    do_reset();
    req_arvalid = one_hot(1);
    req_arlen[8*1 +: 8] = 8'd7;
    step();
    req_arvalid = '0;
    arready_m = 1'b1;
    step();
    arready_m = 1'b0;
    rvalid_m = 1'b1; rid_m = 16'd1; req_rready = one_hot(1);
    repeat (3) step();
    #1;
    chk("m_rvalid_pre", req_rvalid, one_hot(1));
    rst = 1'b0;
    #1;
    chk("m_arvalid", arvalid_m, 0);
    chk("m_rready", rready_m, 0);
    chk("m_rvalid", req_rvalid, 0);
    chk("m_busy", busy, 0);
    step();
    req_arvalid = '1;
    rst = 1'b1;
    #1;
    chk("m_first_grant", req_arready, one_hot(0));
    chk("m_rready_post", rready_m, 0);
    chk("m_rvalid_post", req_rvalid, 0);
    clear_r();
    req_arvalid = '0;

    // Randomized traffic against the round-robin model
    do_reset();
    last = N - 1;
    for (int r = 0; r < 60; r++) begin
      mask = N'($urandom_range(0, (1 << N) - 1));
      for (int k = 0; k < N; k++) begin
        addrs[k] = {$urandom, $urandom};
        lens[k] = 8'($urandom_range(0, 5));
        req_araddr[64*k +: 64] = addrs[k];
        req_arlen[8*k +: 8] = lens[k];
      end
      req_arvalid = mask;
      #1;
      g = rr_pick(last, mask);
      if (g < 0) begin
        chk("r_no_grant", req_arready, 0);
        step();
        continue;
      end
      chk("r_arready", req_arready, one_hot(g));
      step();
      req_arvalid = N'($urandom_range(0, (1 << N) - 1));
      waits = $urandom_range(0, 2);
      for (int w = 0; w <= waits; w++) begin
        arready_m = (w == waits);
        #1;
        chk("r_arvalid", arvalid_m, 1);
        chk("r_arid", arid_m, 64'(g));
        chk("r_araddr", araddr_m, addrs[g]);
        chk("r_no_arready", req_arready, 0);
        step();
      end
      arready_m = 1'b0;
      req_arvalid = '0;
      len = int'(lens[g]);
      b = 0; done = 1'b0;
      for (int c = 0; c < 200 && !done; c++) begin
        d = {$urandom, $urandom};
        rvalid_m = ($urandom_range(0, 3) != 0);
        rid_m = 16'(g);
        rlast_m = (b == len);
        rdata_m = {8{d}};
        req_rready = N'($urandom_range(0, (1 << N) - 1));
        #1;
        chk("r_rvalid", req_rvalid, rvalid_m ? one_hot(g) : '0);
        chk("r_rready", rready_m, req_rready[g]);
        chk("r_rdata", req_rdata[63:0], d);
        if (rvalid_m && req_rready[g]) begin
          b++;
          if (rlast_m) done = 1'b1;
        end
        step();
      end
      clear_r();
      chk("r_done", done, 1);
      chk("r_beats", 64'(b), 64'(len + 1));
      last = g;
    end
    #1;
    chk("r_err", err, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
